// File: rtl/wb_stage_pkg.sv
// Shared core definitions for the write-back stage.
// Provides the load-wait FSM state type and the fixed constants used by
// branch-link writes and the load-timeout watchdog.
package wb_stage_pkg;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Architectural link register index for branch-and-link.
  localparam logic [4:0]  LINK_REG         = 5'd14;
  // Return address is the instruction after the branch.
  localparam logic [31:0] PC_LINK_OFFSET   = 32'd4;
  // Number of WAIT_LOAD cycles tolerated before the load is abandoned.
  localparam logic [7:0]  LOAD_TIMEOUT_MAX = 8'd255;

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: selects the register-file write, updates NZCV flags, keeps a two-deep write history.
// Latency: one clk from acceptance to the write port; a load missing its data waits in WAIT_LOAD.
// Backpressure: stall (combinational) freezes upstream while a load waits; inputs are ignored meanwhile.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   enable_reg_s, read_word_s, enable_write_s, Rd_s, res_s, pc_val_s,
//   link_s, set_s, condition_s, flags_in    instruction from the previous stage
//   d_data_read, d_data_valid  data-memory read return
//   reg_we, reg_waddr, reg_wdata  registered register-file write port
//   word_wb, word_wb_bef       last and second-to-last written values (forwarding)
//   flags                      architectural NZCV
//   stall                      freeze upstream
//   load_timeout               sticky error: a load never received its data
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_reg_s,
  input  logic               read_word_s,
  input  logic               enable_write_s,
  input  logic [4:0]         Rd_s,
  input  logic signed [31:0] res_s,
  input  logic [31:0]        pc_val_s,
  input  logic               link_s,
  input  logic               set_s,
  input  logic               condition_s,
  input  logic [3:0]         flags_in,
  input  logic [31:0]        d_data_read,
  input  logic               d_data_valid,
  output logic               reg_we,
  output logic [4:0]         reg_waddr,
  output logic signed [31:0] reg_wdata,
  output logic signed [31:0] word_wb,
  output logic signed [31:0] word_wb_bef,
  output logic [3:0]         flags,
  output logic               stall,
  output logic               load_timeout
);

  wb_state_e          state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [4:0]         rd_lat_q, rd_lat_d;
  logic               reg_we_q, reg_we_d;
  logic [4:0]         reg_waddr_q, reg_waddr_d;
  logic signed [31:0] reg_wdata_q, reg_wdata_d;
  logic signed [31:0] word_wb_q, word_wb_d;
  logic signed [31:0] word_wb_bef_q, word_wb_bef_d;
  logic [3:0]         flags_q, flags_d;
  logic               load_timeout_q, load_timeout_d;

  logic               sel_we;
  logic [4:0]         sel_addr;
  logic [31:0]        sel_data;
  logic               is_load;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_lat_d       = rd_lat_q;
    reg_we_d       = 1'b0;
    reg_waddr_d    = reg_waddr_q;
    reg_wdata_d    = reg_wdata_q;
    word_wb_d      = word_wb_q;
    word_wb_bef_d  = word_wb_bef_q;
    flags_d        = flags_q;
    load_timeout_d = load_timeout_q;
    stall          = 1'b0;

    // Write select: link beats load beats plain ALU write; stores never write.
    sel_we   = 1'b0;
    sel_addr = Rd_s;
    sel_data = res_s;
    if (link_s) begin
      sel_we   = 1'b1;
      sel_addr = LINK_REG;
      sel_data = pc_val_s + PC_LINK_OFFSET;
    end else if (read_word_s) begin
      sel_we   = 1'b1;
      sel_data = d_data_read;
    end else if (enable_reg_s && !enable_write_s) begin
      sel_we   = 1'b1;
    end

    is_load = condition_s && read_word_s && !link_s;

    // History follows what the register file actually received. WAIT_LOAD
    // never presents a write, so the history is frozen for the whole wait.
    if (reg_we_q) begin
      word_wb_d     = reg_wdata_q;
      word_wb_bef_d = word_wb_q;
    end

    case (state_q)
      ST_RUN: begin
        if (is_load && !d_data_valid) begin
          stall    = 1'b1;
          state_d  = ST_WAIT_LOAD;
          cnt_d    = 8'd0;
          rd_lat_d = Rd_s;
        end else if (condition_s) begin
          if (sel_we && (sel_addr != 5'd0)) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = sel_addr;
            reg_wdata_d = sel_data;
          end
          if (set_s) begin
            flags_d = flags_in;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (d_data_valid) begin
          state_d = ST_RUN;
          if (rd_lat_q != 5'd0) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = rd_lat_q;
            reg_wdata_d = d_data_read;
          end
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
          // This is the last tolerated wait cycle: give up on the load.
          if (cnt_d == LOAD_TIMEOUT_MAX) begin
            load_timeout_d = 1'b1;
            state_d        = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      cnt_q          <= 8'd0;
      rd_lat_q       <= 5'd0;
      reg_we_q       <= 1'b0;
      reg_waddr_q    <= 5'd0;
      reg_wdata_q    <= '0;
      word_wb_q      <= '0;
      word_wb_bef_q  <= '0;
      flags_q        <= 4'd0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_lat_q       <= rd_lat_d;
      reg_we_q       <= reg_we_d;
      reg_waddr_q    <= reg_waddr_d;
      reg_wdata_q    <= reg_wdata_d;
      word_wb_q      <= word_wb_d;
      word_wb_bef_q  <= word_wb_bef_d;
      flags_q        <= flags_d;
      load_timeout_q <= load_timeout_d;
    end
  end

  assign reg_we       = reg_we_q;
  assign reg_waddr    = reg_waddr_q;
  assign reg_wdata    = reg_wdata_q;
  assign word_wb      = word_wb_q;
  assign word_wb_bef  = word_wb_bef_q;
  assign flags        = flags_q;
  assign load_timeout = load_timeout_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scoreboarded register writes plus directed checks of
// flags, forwarding history, stall and load timeout.
module tb_wb_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable_reg_s, read_word_s, enable_write_s;
  logic [4:0]         Rd_s;
  logic signed [31:0] res_s;
  logic [31:0]        pc_val_s;
  logic               link_s, set_s, condition_s;
  logic [3:0]         flags_in;
  logic [31:0]        d_data_read;
  logic               d_data_valid;
  logic               reg_we;
  logic [4:0]         reg_waddr;
  logic signed [31:0] reg_wdata, word_wb, word_wb_bef;
  logic [3:0]         flags;
  logic               stall, load_timeout;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_stall;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .enable_reg_s(enable_reg_s), .read_word_s(read_word_s), .enable_write_s(enable_write_s),
    .Rd_s(Rd_s), .res_s(res_s), .pc_val_s(pc_val_s), .link_s(link_s), .set_s(set_s),
    .condition_s(condition_s), .flags_in(flags_in),
    .d_data_read(d_data_read), .d_data_valid(d_data_valid),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .word_wb(word_wb), .word_wb_bef(word_wb_bef), .flags(flags),
    .stall(stall), .load_timeout(load_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable_reg_s = 1'b0; read_word_s = 1'b0; enable_write_s = 1'b0;
    Rd_s = 5'd0; res_s = '0; pc_val_s = '0; link_s = 1'b0; set_s = 1'b0;
    condition_s = 1'b0; flags_in = 4'd0; d_data_read = '0; d_data_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    idle();
    enable_reg_s = 1'b1; condition_s = 1'b1; Rd_s = rd; res_s = val;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every write the DUT presents must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (!reset && reg_we) begin
      chk("waddr_nonzero", {31'd0, reg_waddr != 5'd0}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, reg_waddr}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", {27'd0, reg_waddr}, {27'd0, e.addr});
        chk("wdata", reg_wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r_link, r_en, r_wr, r_cond;
    logic [4:0] r_rd;
    logic [31:0] r_res, r_pc;

    idle();
    reset = 1'b1;
    step(); step();
    chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
    chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_word_wb", word_wb, 32'd0);
    chk("rst_word_wb_bef", word_wb_bef, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_timeout", {31'd0, load_timeout}, 32'd0);
    reset = 1'b0;
    step();

    // ALU write, then history one clk later.
    alu(5'd3, 32'h12345678); push(5'd3, 32'h12345678);
    step();
    chk("alu_reg_we", {31'd0, reg_we}, 32'd1);
    idle(); step();
    chk("alu_word_wb", word_wb, 32'h12345678);

    // Branch-link, including PC wrap.
    alu(5'd7, 32'h0BAD0BAD); link_s = 1'b1; pc_val_s = 32'h100; push(5'd14, 32'h104);
    step();
    pc_val_s = 32'hFFFFFFFC; push(5'd14, 32'h0);
    step();
    idle(); step();

    // Flags: load a known value, then a condition-failed update must not touch it.
    idle(); set_s = 1'b1; condition_s = 1'b1; flags_in = 4'b0101;
    step(); idle(); step();
    chk("flags_set", {28'd0, flags}, 32'h5);
    alu(5'd4, 32'h77); set_s = 1'b1; flags_in = 4'b1010; condition_s = 1'b0;
    step();
    chk("cond_fail_we", {31'd0, reg_we}, 32'd0);
    idle(); step();
    chk("cond_fail_flags", {28'd0, flags}, 32'h5);

    // Forwarding history.
    alu(5'd1, 32'h1); push(5'd1, 32'h1); step();
    alu(5'd2, 32'h2); push(5'd2, 32'h2); step();
    alu(5'd3, 32'h3); push(5'd3, 32'h3); step();
    idle(); step();
    chk("hist_word_wb", word_wb, 32'h3);
    chk("hist_word_wb_bef", word_wb_bef, 32'h2);
    alu(5'd0, 32'h99); step();
    chk("r0_reg_we", {31'd0, reg_we}, 32'd0);
    idle(); step(); step();
    chk("r0_word_wb", word_wb, 32'h3);
    chk("r0_word_wb_bef", word_wb_bef, 32'h2);

    // Stalled load with junk upstream inputs during the stall.
    idle(); read_word_s = 1'b1; condition_s = 1'b1; Rd_s = 5'd5;
    #1; chk("ld_stall_c1", {31'd0, stall}, 32'd1);
    step();
    alu(5'd9, 32'hDEAD); link_s = 1'b1; set_s = 1'b1; flags_in = 4'hF;
    #1; chk("ld_stall_c2", {31'd0, stall}, 32'd1);
    step();
    #1; chk("ld_stall_c3", {31'd0, stall}, 32'd1);
    chk("ld_hist_frozen", word_wb, 32'h3);
    step();
    d_data_valid = 1'b1; d_data_read = 32'hCAFEBABE; push(5'd5, 32'hCAFEBABE);
    #1; chk("ld_stall_c4", {31'd0, stall}, 32'd0);
    step();
    idle(); step(); step();
    chk("ld_word_wb", word_wb, 32'hCAFEBABE);
    chk("ld_word_wb_bef", word_wb_bef, 32'h3);
    chk("ld_flags_kept", {28'd0, flags}, 32'h5);

    // Load timeout: entry cycle plus 255 wait cycles of stall.
    idle(); read_word_s = 1'b1; condition_s = 1'b1; Rd_s = 5'd6;
    #1; n_stall = (stall == 1'b1) ? 1 : 0;
    step();
    idle();
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!stall) break;
      n_stall++;
      chk("to_pending", {31'd0, load_timeout}, 32'd0);
      step();
    end
    chk("to_stall_cycles", n_stall, 32'd256);
    chk("to_flag", {31'd0, load_timeout}, 32'd1);
    alu(5'd8, 32'h88); push(5'd8, 32'h88);
    step();
    idle(); step();
    chk("to_sticky", {31'd0, load_timeout}, 32'd1);

    // Reset abandons a pending load, even with data arriving.
    idle(); read_word_s = 1'b1; condition_s = 1'b1; Rd_s = 5'd7;
    step(); idle(); step();
    #1; chk("rst_wait_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1; d_data_valid = 1'b1; d_data_read = 32'h55;
    step();
    idle();
    #1; chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_timeout", {31'd0, load_timeout}, 32'd0);
    chk("rst_mid_we", {31'd0, reg_we}, 32'd0);
    reset = 1'b0;
    step(); step();

    // Random non-load traffic against a reference write-select model.
    for (int i = 0; i < 24; i++) begin
      r_link = ($urandom_range(0, 3) == 0);
      r_en   = 1'($urandom_range(0, 1));
      r_wr   = ($urandom_range(0, 3) == 0);
      r_cond = ($urandom_range(0, 3) != 0);
      r_rd   = 5'($urandom_range(0, 31));
      r_res  = $urandom;
      r_pc   = $urandom;
      idle();
      link_s = r_link; enable_reg_s = r_en; enable_write_s = r_wr;
      condition_s = r_cond; Rd_s = r_rd; res_s = r_res; pc_val_s = r_pc;
      if (r_cond) begin
        if (r_link) push(5'd14, r_pc + 32'd4);
        else if (r_en && !r_wr && r_rd != 5'd0) push(r_rd, r_res);
      end
      step();
    end
    idle(); step(); step();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk in 1, single clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have inputs: enable_reg_s 1 (writes Rd); read_word_s 1 (load); enable_write_s 1 (store, no register write); Rd_s 5 (dest index); res_s 32 signed (ALU result); pc_val_s 32 (instr PC); link_s 1 (branch-link); set_s 1 (update flags); condition_s 1 (condition passed); flags_in 4 (NZCV from ALU); d_data_read 32 (memory read data); d_data_valid 1 (read data present).
REQ-003 SHALL have outputs: reg_we 1; reg_waddr 5; reg_wdata 32 signed; word_wb 32 signed (last written value); word_wb_bef 32 signed (value written one cycle earlier); flags 4 (architectural NZCV); stall 1 (freeze upstream); load_timeout 1 (sticky error).

Function
REQ-004 SHALL be a registered stage: the write port (reg_we/reg_waddr/reg_wdata) reflects the instruction one clk after it is accepted.
REQ-005 SHALL accept an instruction each cycle while in RUN; inputs are ignored while stall=1.
REQ-006 SHALL suppress the register write and the flag update when condition_s=0.
REQ-007 SHALL select the write: link_s=1 -> waddr 14, wdata pc_val_s+4 (mod 2^32); else read_word_s=1 -> waddr Rd_s, wdata d_data_read; else enable_reg_s=1 and enable_write_s=0 -> waddr Rd_s, wdata res_s; else reg_we=0.
REQ-008 SHALL give link_s priority over read_word_s and enable_reg_s when several are set.
REQ-009 SHALL never assert reg_we with reg_waddr=0.
REQ-010 SHALL load flags<=flags_in one clk after acceptance when set_s=1 and condition_s=1; flags otherwise hold.
REQ-011 SHALL implement FSM RUN/WAIT_LOAD: in RUN, an accepted load (read_word_s=1, condition_s=1, link_s=0) with d_data_valid=0 -> WAIT_LOAD, latching Rd_s, and stall=1 combinationally in that same cycle.
REQ-012 SHALL, in WAIT_LOAD, hold stall=1 and reg_we=0; on d_data_valid=1 write d_data_read to the latched Rd next clk, return to RUN, and drop stall in the cycle d_data_valid is seen.
REQ-013 SHALL complete a load arriving with d_data_valid=1 in RUN with no stall.
REQ-014 SHALL count WAIT_LOAD cycles with an 8-bit counter cleared on WAIT_LOAD entry; at count 255 set load_timeout=1 (sticky until reset), discard the load and return to RUN.
REQ-015 SHALL update word_wb<=reg_wdata and word_wb_bef<=word_wb only on cycles with reg_we=1, providing two-deep forwarding history for the memory stage.
REQ-016 SHALL leave flags, word_wb and word_wb_bef unchanged during stall cycles.

Reset
REQ-017 SHALL, when reset=1 at a clk edge, set reg_we=0, reg_waddr=0, reg_wdata=0, word_wb=0, word_wb_bef=0, flags=0, stall=0, load_timeout=0, counter=0, FSM=RUN.
REQ-018 SHALL abandon a pending WAIT_LOAD on reset without writing.
REQ-019 SHALL take reset priority over all other inputs, including d_data_valid.

Structure
REQ-020 SHALL import from the shared core package: the FSM state enum, LINK_REG=5'd14, PC_LINK_OFFSET=32'd4, LOAD_TIMEOUT_MAX=8'd255.
REQ-021 SHALL be one module with no sub-modules; the write-select mux stays inline.

Verification
REQ-022 ALU write: enable_reg_s=1, Rd_s=3, res_s=0x12345678, condition_s=1 -> next clk reg_we=1, waddr=3, wdata=0x12345678; word_wb=0x12345678 the clk after.
REQ-023 Branch-link: link_s=1, enable_reg_s=1, pc_val_s=0x100 -> waddr=14, wdata=0x104; pc_val_s=0xFFFFFFFC -> wdata=0x0.
REQ-024 Stalled load: read_word_s=1, Rd_s=5, d_data_valid=0 for 3 cycles then 1 with d_data_read=0xCAFEBABE -> stall high 3 cycles; one write of 0xCAFEBABE to r5; upstream inputs during the stall ignored.
REQ-025 Condition fail: set_s=1, flags_in=4'b1010, enable_reg_s=1, condition_s=0 -> reg_we=0, flags unchanged.
REQ-026 Forwarding history: writes 0x1, 0x2, 0x3 on consecutive cycles -> after the third, word_wb=0x3, word_wb_bef=0x2; Rd_s=0 write -> reg_we=0, history unchanged.
REQ-027 Timeout/reset: load with d_data_valid held 0 -> load_timeout=1 after 255 wait cycles, back in RUN; reset asserted mid-WAIT_LOAD -> stall=0, no write, load_timeout=0.
